// File: rtl/serial_frame_pkg.sv
// Shared types for the serial frame receiver.
// Holds the receiver FSM state encoding and a width helper used by the
// top level and the bit timer.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;

    // Counter width for a given count range, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

    // Bit timer width for the default line rate of 16 clocks per bit.
    localparam int CNT_W = clog2_min1(16);

endpackage

// File: rtl/serial_frame_rx_bit_timer.sv
// Bit timer for the serial frame receiver.
// A loadable down-counter: a load arms it for half a bit period (centre of
// the start bit), after which each expiry re-arms it for a full bit period.
// sample_tick marks the cycle on which the line is to be sampled.
module bit_timer
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic sample_tick
);

    localparam int TIMER_W = clog2_min1(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_M1 = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_M1 = TIMER_W'(CLKS_PER_BIT - 1);

    logic [TIMER_W-1:0] cnt;

    // Count down while running; reload a full bit period on each expiry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= HALF_M1;
        end else if (run) begin
            cnt <= (cnt == '0) ? FULL_M1 : cnt - TIMER_W'(1);
        end
    end

    assign sample_tick = run && (cnt == '0);

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: recovers LSB-first frames (start, DATA_W data bits,
// optional even parity, stop) from an asynchronous line and presents each
// word on a valid/ready handshake. Flags framing, overrun and parity errors.
// Optional parity checking is enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rxd,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int IDX_W = clog2_min1(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t             state, state_nx;
    logic               rxd_meta, rxd_s;
    logic               tick;
    logic               timer_load, timer_run;
    logic               shift_en, word_done, frame_bad, parity_bad;
    logic [DATA_W-1:0]  shift_q;
    logic [IDX_W-1:0]   bit_idx;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic               par_bad_q;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking so rxd_s takes the old rxd_meta, giving two real stages.
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock       (clock),
        .reset       (reset),
        .load        (timer_load),
        .run         (timer_run),
        .sample_tick (tick)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            IDLE:    if (!rxd_s) state_nx = START;
            START:   if (tick) state_nx = rxd_s ? IDLE : DATA;
            DATA: begin
                if (tick && bit_idx == LAST_IDX) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
            PARITY:  if (tick) state_nx = STOP;
            STOP:    if (tick) state_nx = rxd_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rxd_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: timer control and per-frame completion decisions.
    always_comb begin
        timer_load = (state == IDLE) && !rxd_s;
        timer_run  = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
        shift_en   = (state == DATA) && tick;
        frame_bad  = (state == STOP) && tick && !rxd_s;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        word_done  = (state == STOP) && tick && rxd_s && !par_bad_q;
        parity_bad = (state == STOP) && tick && rxd_s && par_bad_q;
`else
        word_done  = (state == STOP) && tick && rxd_s;
        parity_bad = 1'b0;
`endif
    end

    // Shift register (LSB arrives first, so bits enter at the MSB) and bit index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            bit_idx <= '0;
        end else begin
            if (timer_load)    bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + IDX_W'(1);
            if (shift_en) shift_q <= (shift_q >> 1) | (DATA_W'(rxd_s) << (DATA_W - 1));
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                           par_bad_q <= 1'b0;
        else if (timer_load)                  par_bad_q <= 1'b0;
        else if ((state == PARITY) && tick)   par_bad_q <= ^{shift_q, rxd_s};
    end

    // Registered parity error pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) parity_err <= 1'b0;
        else        parity_err <= parity_bad;
    end
`else
    assign parity_err = parity_bad;
`endif

    // Output holding register, handshake and error pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= word_done && valid && !ready;
            if (word_done && (!valid || ready)) begin
                dout  <= shift_q;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx (DATA_W=8, CLKS_PER_BIT=16).
// Define SERIAL_FRAME_RX_PARITY_EN for both bench and RTL to cover parity.
module tb_serial_frame_rx;

    localparam int DATA_W = 8;
    localparam int CPB    = 16;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Cycles from the rxd falling edge to the first cycle valid/pulses are seen.
    localparam int EXP_LAT = CPB / 2 + (DATA_W + 1 + PB) * CPB + 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              rxd;
    logic              ready;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

    serial_frame_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rxd        (rxd),
        .dout       (dout),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int          cyc, first_valid, valid_cnt;
    int          fe_cnt, fe_at, ov_cnt, ov_at, pe_cnt, pe_at;
    logic [7:0]  first_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; first_valid = -1; valid_cnt = 0; first_dout = '0;
        fe_cnt = 0; fe_at = -1; ov_cnt = 0; ov_at = -1; pe_cnt = 0; pe_at = -1;
    endtask

    // One clock: advance past the edge, then record what the outputs show.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (valid) begin
            valid_cnt++;
            if (first_valid < 0) begin
                first_valid = cyc;
                first_dout  = dout;
            end
        end
        if (frame_err)  begin fe_cnt++; fe_at = cyc; end
        if (overrun)    begin ov_cnt++; ov_at = cyc; end
        if (parity_err) begin pe_cnt++; pe_at = cyc; end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    // Drive n line bits (LSB first), each for one bit period; cyc restarts at 0.
    task automatic send_bits(input logic [31:0] bits, input int n);
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            repeat (CPB) tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        logic [31:0] v;
        int n;
        v      = '0;
        v[8:1] = d;
        n      = 9;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        v[9] = (^d) ^ par_flip;
        n    = 10;
`else
        if (par_flip) v = v;
`endif
        v[n] = stop_b;
        send_bits(v, n + 1);
    endtask

    initial begin
        reset = 1'b0;
        rxd   = 1'b1;
        ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clock);
        #1;

        // Reset state
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        reset = 1'b1;
        idle(5);

        // 1: 0xA5 with ready high
        clear_mon();
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_latency", first_valid, EXP_LAT);
        check("t1_dout", 32'(first_dout), 32'hA5);
        check("t1_valid_len", valid_cnt, 1);
        check("t1_pulses", fe_cnt + ov_cnt + pe_cnt, 0);
        idle(5);

        // 2: false start (6 cycles low), then a normal frame proves IDLE
        clear_mon();
        rxd = 1'b0;
        repeat (6) tick();
        idle(40);
        check("t2_no_valid", valid_cnt, 0);
        check("t2_no_pulses", fe_cnt + ov_cnt + pe_cnt, 0);
        clear_mon();
        send_frame(8'h96, 1'b1, 1'b0);
        check("t2_next_latency", first_valid, EXP_LAT);
        check("t2_next_dout", 32'(first_dout), 32'h96);
        idle(5);

        // 3: bad stop bit, then a good frame
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        check("t3_fe_count", fe_cnt, 1);
        check("t3_fe_time", fe_at, EXP_LAT);
        check("t3_no_valid", valid_cnt, 0);
        check("t3_other_pulses", ov_cnt + pe_cnt, 0);
        clear_mon();
        send_frame(8'h11, 1'b1, 1'b0);
        check("t3_next_latency", first_valid, EXP_LAT);
        check("t3_next_dout", 32'(first_dout), 32'h11);
        check("t3_next_no_fe", fe_cnt, 0);
        idle(5);

        // 4: overrun with ready low, back-to-back frames
        ready = 1'b0;
        clear_mon();
        send_frame(8'h01, 1'b1, 1'b0);
        check("t4_first_latency", first_valid, EXP_LAT);
        send_frame(8'h02, 1'b1, 1'b0);
        idle(10);
        check("t4_valid_held", 32'(valid), 32'h1);
        check("t4_dout_old", 32'(dout), 32'h01);
        check("t4_ov_count", ov_cnt, 1);
        check("t4_ov_time", ov_at, EXP_LAT);
        check("t4_no_fe", fe_cnt + pe_cnt, 0);
        ready = 1'b1;
        tick();
        check("t4_consumed_valid", 32'(valid), 32'h0);
        check("t4_consumed_dout", 32'(dout), 32'h01);
        idle(5);

        // 5: reset mid-DATA of 0xFF, then 0x5A
        clear_mon();
        send_bits(32'h1FE, 4);
        reset = 1'b0;
        #1;
        check("t5_rst_dout", 32'(dout), 32'h0);
        check("t5_rst_valid", 32'(valid), 32'h0);
        check("t5_rst_pulses", 32'({frame_err, overrun, parity_err}), 32'h0);
        rxd = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        idle(5);
        clear_mon();
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t5_next_latency", first_valid, EXP_LAT);
        check("t5_next_dout", 32'(first_dout), 32'h5A);
        check("t5_next_pulses", fe_cnt + ov_cnt + pe_cnt, 0);
        idle(5);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        // 6: parity good then parity bad
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0);
        check("t6_good_latency", first_valid, 171);
        check("t6_good_dout", 32'(first_dout), 32'h07);
        check("t6_good_no_pe", pe_cnt, 0);
        idle(5);
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        check("t6_bad_pe_count", pe_cnt, 1);
        check("t6_bad_pe_time", pe_at, 171);
        check("t6_bad_no_valid", valid_cnt, 0);
        check("t6_bad_no_fe", fe_cnt + ov_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
